// File: rtl/cpu_bus_mux_if.sv
// Signal bundle for the PicoRV32 native-bus read/ready multiplexer.
// The master side drives the CPU and slave inputs; the mux side drives the outputs.
interface cpu_bus_mux_if #(
    parameter int N_SLAVES   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]          i_la_addr;
    logic                           i_valid;
    logic                           o_ready;
    logic [DATA_WIDTH-1:0]          o_rdata;
    logic [N_SLAVES*DATA_WIDTH-1:0] i_slave_rdata;
    logic [N_SLAVES-1:0]            o_slave_valid;
    logic [N_SLAVES-1:0]            i_slave_ready;
    logic                           o_timeout;

    modport master (
        output i_la_addr,
        output i_valid,
        output i_slave_rdata,
        output i_slave_ready,
        input  o_ready,
        input  o_rdata,
        input  o_slave_valid,
        input  o_timeout
    );

    modport slave (
        input  i_la_addr,
        input  i_valid,
        input  i_slave_rdata,
        input  i_slave_ready,
        output o_ready,
        output o_rdata,
        output o_slave_valid,
        output o_timeout
    );
endinterface

// File: rtl/cpu_bus_mux.sv
// Single-master to N-slave read/ready mux for the PicoRV32 native bus.
// Optional stall watchdog: define CPU_BUS_MUX_TIMEOUT_EN (adds o_timeout).
module cpu_bus_mux #(
    parameter int N_SLAVES   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0100_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_0000},
    parameter logic [DATA_WIDTH-1:0] UNMAPPED_RDATA = '0
`ifdef CPU_BUS_MUX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          i_la_addr,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] i_slave_rdata,
    output logic [N_SLAVES-1:0]            o_slave_valid,
    input  logic [N_SLAVES-1:0]            i_slave_ready
`ifdef CPU_BUS_MUX_TIMEOUT_EN
    ,
    output logic                           o_timeout
`endif
);

    logic [N_SLAVES-1:0]   dec;
    logic                  dec_found;
    logic [N_SLAVES-1:0]   sel_q;
    logic [N_SLAVES-1:0]   sel_d;
    logic                  unmapped_q;
    logic                  unmapped_d;
    logic                  slv_ready;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic                  to_fire;

    // Priority decode: lowest index wins on overlap, so dec is one-hot or zero.
    always_comb begin
        dec       = '0;
        dec_found = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (!dec_found &&
                ((i_la_addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec[k]    = 1'b1;
                dec_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_d      = sel_q;
        unmapped_d = unmapped_q;
        if (!i_valid) begin
            sel_d      = dec;
            unmapped_d = (dec == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q      <= '0;
            unmapped_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            unmapped_q <= unmapped_d;
        end
    end

    always_comb begin
        slv_ready = 1'b0;
        slv_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q[k]) begin
                slv_ready = slv_ready | i_slave_ready[k];
                slv_rdata = slv_rdata | i_slave_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef CPU_BUS_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign to_fire = i_valid & ~slv_ready & ~unmapped_q &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_valid || o_ready) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_timeout = to_fire & ~reset;
`else
    assign to_fire = 1'b0;
`endif

    assign o_slave_valid = {N_SLAVES{i_valid & ~reset}} & sel_q;
    assign o_ready = ~reset & i_valid & (slv_ready | unmapped_q | to_fire);

    always_comb begin
        o_rdata = '0;
        if (!reset && i_valid) begin
            if (unmapped_q || to_fire) begin
                o_rdata = UNMAPPED_RDATA;
            end else begin
                o_rdata = slv_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_mux.sv
// Directed bench for cpu_bus_mux: decode, routing, hold, reset, stall/timeout.
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_cpu_bus_mux;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    cpu_bus_mux_if #(.N_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cpu_bus_mux #(
`ifdef CPU_BUS_MUX_TIMEOUT_EN
        .TIMEOUT_CYCLES(8),
`endif
        .N_SLAVES(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_la_addr     (bus.i_la_addr),
        .i_valid       (bus.i_valid),
        .o_ready       (bus.o_ready),
        .o_rdata       (bus.o_rdata),
        .i_slave_rdata (bus.i_slave_rdata),
        .o_slave_valid (bus.o_slave_valid),
        .i_slave_ready (bus.i_slave_ready)
`ifdef CPU_BUS_MUX_TIMEOUT_EN
        ,
        .o_timeout     (bus.o_timeout)
`endif
    );

`ifndef CPU_BUS_MUX_TIMEOUT_EN
    assign bus.o_timeout = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.i_la_addr     = 32'h0;
        bus.i_valid       = 1'b0;
        bus.i_slave_rdata = '0;
        bus.i_slave_ready = '0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_sv", 32'(bus.o_slave_valid), 32'd0);
        chk("rst_rdata", bus.o_rdata, 32'd0);

        // slave0, one wait state; slave1 ready must be ignored
        reset = 1'b0;
        bus.i_la_addr = 32'h0000_0100;
        tick();
        bus.i_valid = 1'b1;
        bus.i_slave_rdata = {32'h1111_1111, 32'hDEAD_BEEF};
        bus.i_slave_ready = 2'b10;
        settle();
        chk("s0_sv", 32'(bus.o_slave_valid), 32'd1);
        chk("s0_wait_ready", 32'(bus.o_ready), 32'd0);
        tick();
        bus.i_slave_ready = 2'b01;
        settle();
        chk("s0_ready", 32'(bus.o_ready), 32'd1);
        chk("s0_rdata", bus.o_rdata, 32'hDEAD_BEEF);
        tick();
        bus.i_valid = 1'b0;
        bus.i_slave_ready = 2'b00;
        settle();
        chk("idle_ready", 32'(bus.o_ready), 32'd0);
        chk("idle_rdata", bus.o_rdata, 32'd0);
        chk("idle_sv", 32'(bus.o_slave_valid), 32'd0);

        // slave1, zero wait states
        bus.i_la_addr = 32'h0100_0004;
        tick();
        bus.i_valid = 1'b1;
        bus.i_slave_rdata = {32'h0000_00A5, 32'h5555_5555};
        bus.i_slave_ready = 2'b10;
        settle();
        chk("s1_sv", 32'(bus.o_slave_valid), 32'd2);
        chk("s1_ready", 32'(bus.o_ready), 32'd1);
        chk("s1_rdata", bus.o_rdata, 32'h0000_00A5);
        tick();
        bus.i_valid = 1'b0;
        bus.i_slave_ready = 2'b00;

        // unmapped: immediate acknowledge with zero data
        bus.i_la_addr = 32'h0200_0000;
        tick();
        bus.i_valid = 1'b1;
        settle();
        chk("um_sv", 32'(bus.o_slave_valid), 32'd0);
        chk("um_ready", 32'(bus.o_ready), 32'd1);
        chk("um_rdata", bus.o_rdata, 32'd0);
        tick();
        bus.i_valid = 1'b0;

        // range edges
        bus.i_la_addr = 32'h0000_FFFC;
        tick();
        bus.i_valid = 1'b1;
        settle();
        chk("edge_s0_top", 32'(bus.o_slave_valid), 32'd1);
        tick();
        bus.i_valid = 1'b0;
        bus.i_la_addr = 32'h0100_0FFC;
        tick();
        bus.i_valid = 1'b1;
        settle();
        chk("edge_s1_top", 32'(bus.o_slave_valid), 32'd2);
        tick();
        bus.i_valid = 1'b0;
        bus.i_la_addr = 32'h0100_1000;
        tick();
        bus.i_valid = 1'b1;
        settle();
        chk("edge_s1_past_sv", 32'(bus.o_slave_valid), 32'd0);
        chk("edge_s1_past_rdy", 32'(bus.o_ready), 32'd1);
        tick();
        bus.i_valid = 1'b0;
        bus.i_la_addr = 32'h0001_0000;
        tick();
        bus.i_valid = 1'b1;
        settle();
        chk("edge_s0_past_sv", 32'(bus.o_slave_valid), 32'd0);
        tick();
        bus.i_valid = 1'b0;

        // address change mid-transaction is ignored
        bus.i_la_addr = 32'h0000_0000;
        tick();
        bus.i_valid = 1'b1;
        bus.i_la_addr = 32'h0100_0000;
        tick();
        chk("hold_sv", 32'(bus.o_slave_valid), 32'd1);
        chk("hold_ready", 32'(bus.o_ready), 32'd0);
        bus.i_slave_rdata = {32'h0000_00A5, 32'h0000_1234};
        bus.i_slave_ready = 2'b01;
        settle();
        chk("hold_rdata", bus.o_rdata, 32'h0000_1234);
        tick();
        bus.i_valid = 1'b0;
        bus.i_slave_ready = 2'b00;
        tick();
        bus.i_valid = 1'b1;
        bus.i_slave_ready = 2'b10;
        settle();
        chk("retrack_sv", 32'(bus.o_slave_valid), 32'd2);

        // reset mid-transaction on slave1
        reset = 1'b1;
        settle();
        chk("midrst_sv", 32'(bus.o_slave_valid), 32'd0);
        chk("midrst_ready", 32'(bus.o_ready), 32'd0);
        chk("midrst_rdata", bus.o_rdata, 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("postrst_sv", 32'(bus.o_slave_valid), 32'd0);
        chk("postrst_ready", 32'(bus.o_ready), 32'd0);
        bus.i_valid = 1'b0;
        bus.i_slave_ready = 2'b00;

        // non-responding slave0
        bus.i_la_addr = 32'h0000_0100;
        bus.i_slave_rdata = {32'h0000_00A5, 32'h0000_CAFE};
        tick();
        bus.i_valid = 1'b1;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            settle();
            if (i < 8) begin
                chk($sformatf("to_wait_ready_%0d", i), 32'(bus.o_ready), 32'd0);
                chk($sformatf("to_wait_flag_%0d", i), 32'(bus.o_timeout), 32'd0);
            end else begin
                chk("to_ready", 32'(bus.o_ready), 32'd1);
                chk("to_flag", 32'(bus.o_timeout), 32'd1);
                chk("to_rdata", bus.o_rdata, 32'd0);
            end
            if (i < 8) tick();
        end
`else
        for (int i = 1; i <= 12; i++) begin
            settle();
            chk($sformatf("stall_ready_%0d", i), 32'(bus.o_ready), 32'd0);
            if (i < 12) tick();
        end
`endif
        tick();
        bus.i_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
